// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer and its watchdog.
package count_seq_pkg;

  localparam int NB_BITS_DEF = 4;
  localparam int RUNS_W_DEF  = 8;

  // Sequencer states; a run walks IDLE -> CLEAR -> RUN -> DONE -> IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Watchdog for the count sequencer: counts RUN cycles that drive an increment
// and flags a timeout on the 2^NB_BITS-th such cycle. A healthy counter never
// needs more than 2^NB_BITS-1 increments to reach any target, so the timeout
// can only fire when the downstream counter is not following enable.
module seq_watchdog #(
  parameter int NB_BITS = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,   // hold the count at zero (outside RUN)
  input  logic tick_i,    // one increment cycle observed
  output logic timeout_o  // this tick is the 2^NB_BITS-th one
);

  logic [NB_BITS-1:0] wd_cnt_q;
  logic [NB_BITS-1:0] wd_cnt_d;

  // Timeout when the count is already all-ones and another tick arrives.
  always_comb begin
    timeout_o = tick_i && (wd_cnt_q == {NB_BITS{1'b1}});
  end

  // Next count: clear has priority, otherwise advance on each tick.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clear_i) begin
      wd_cnt_d = '0;
    end else if (tick_i) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Count sequencer: drives init/enable of an external up-counter so that it
// clears, counts up to a latched target and stops there, then pulses done.
//
// Control semantics: start_i is a request sampled only in IDLE or ERROR and
// accepted on the clock edge where it is seen high with stop_i low; there is
// no acknowledge other than busy_o rising. stop_i is a level that aborts the
// current activity on the next edge and always wins over start and over
// completion. hold_i freezes increments but never changes state flow.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int NB_BITS = NB_BITS_DEF,
  parameter int RUNS_W  = RUNS_W_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              hold_i,
  input  logic [NB_BITS-1:0] target_i,
  input  logic [NB_BITS-1:0] count_i,
  output logic              enable_o,
  output logic              init_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [RUNS_W-1:0] runs_o,
  output state_t            dbg_state_o
);

  state_t              state_q, state_d;
  logic [NB_BITS-1:0]  target_q, target_d;
  logic [RUNS_W-1:0]   runs_q, runs_d;
  logic                err_q, err_d;

  logic                at_target;
  logic                wd_clear;
  logic                wd_tick;
  logic                wd_timeout;

  seq_watchdog #(
    .NB_BITS (NB_BITS)
  ) u_watchdog (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .clear_i   (wd_clear),
    .tick_i    (wd_tick),
    .timeout_o (wd_timeout)
  );

  // The counter has reached the latched terminal value.
  always_comb begin
    at_target = (count_i == target_q);
  end

  // Next-state and output decode; every output defaults to inactive.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    runs_d   = runs_q;
    err_d    = err_q;
    enable_o = 1'b0;
    init_o   = 1'b0;
    done_o   = 1'b0;
    wd_clear = 1'b1;
    wd_tick  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          target_d = target_i;
          state_d  = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        init_o  = 1'b1;
        state_d = stop_i ? ST_IDLE : ST_RUN;
      end

      ST_RUN: begin
        // Increment only while short of target and not paused; the watchdog
        // sees exactly the cycles that request an increment.
        wd_clear = 1'b0;
        enable_o = !hold_i && !at_target;
        wd_tick  = enable_o;
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (at_target) begin
          state_d = ST_DONE;
        end else if (wd_timeout) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end

      ST_DONE: begin
        // An abort in the completion cycle suppresses the pulse and the tally.
        if (!stop_i) begin
          done_o = 1'b1;
          if (runs_q != {RUNS_W{1'b1}}) begin
            runs_d = runs_q + 1'b1;
          end
        end
        state_d = ST_IDLE;
      end

      ST_ERROR: begin
        if (stop_i) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (start_i) begin
          err_d    = 1'b0;
          target_d = target_i;
          state_d  = ST_CLEAR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched target, run tally and error flag registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      runs_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      runs_q   <= runs_d;
      err_q    <= err_d;
    end
  end

  // Status outputs taken straight from registered state.
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    err_o       = err_q;
    runs_o      = runs_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a behavioural downstream counter, a queue of
// expected done cycles computed from target/latency arithmetic, a per-cycle
// compare process and directed scenarios with literal expectations.
module tb_count_sequencer;
  import count_seq_pkg::*;

  localparam int NB = 4;
  localparam int RW = 8;

  // ---------------- clock / reset ----------------
  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_i = ~clock_i;

  logic          start_i = 1'b0;
  logic          stop_i  = 1'b0;
  logic          hold_i  = 1'b0;
  logic [NB-1:0] target_i = '0;
  logic [NB-1:0] count_i;
  logic          enable_o, init_o, busy_o, done_o, err_o;
  logic [RW-1:0] runs_o;
  state_t        dbg_state;

  count_sequencer #(.NB_BITS(NB), .RUNS_W(RW)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .hold_i      (hold_i),
    .target_i    (target_i),
    .count_i     (count_i),
    .enable_o    (enable_o),
    .init_o      (init_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .runs_o      (runs_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- downstream counter model ----------------
  logic [NB-1:0] m_count = '0;
  bit            m_stuck = 1'b0;
  assign count_i = m_stuck ? '0 : m_count;

  always @(posedge clock_i) begin
    if (init_o) m_count <= '0;
    else if (enable_o) m_count <= m_count + 1'b1;
  end

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];   // cycles in which done_o must be high
  int m_runs = 0;          // expected completed-run tally (saturating)
  int en_seen = 0;
  int init_seen = 0;
  int last_done = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clock_i) begin
    bit exp_done;
    exp_done = 1'b0;
    if (reset_i) begin
      m_runs = 0;
      exp_q.delete();
    end
    check("runs_cycle", 32'(runs_o), 32'(m_runs));
    if (exp_q.size() > 0 && exp_q[0] == 32'(cyc)) begin
      exp_done = 1'b1;
      void'(exp_q.pop_front());
    end
    check("done_cycle", {31'd0, done_o}, {31'd0, exp_done});
    check("init_en_excl", {31'd0, init_o & enable_o}, 32'd0);
    if (enable_o) en_seen++;
    if (init_o) init_seen++;
    if (done_o) last_done = cyc;
    if (exp_done && m_runs < (2**RW - 1)) m_runs++;
  end

  // ---------------- driver tasks ----------------
  // All drivers resume 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  // Pulse start; the returned cycle is the accepting edge. When a completion
  // is expected, done must appear target+2+hold_cycles cycles later.
  task automatic start_run(input logic [NB-1:0] t, input int hold_cycles,
                           input bit expect_done, output int acc);
    target_i = t;
    start_i  = 1'b1;
    tick(1);
    acc     = cyc;
    start_i = 1'b0;
    if (expect_done) exp_q.push_back(32'(acc + int'(t) + 2 + hold_cycles));
  endtask

  task automatic check_all_low(input string name);
    check(name, {26'd0, enable_o, init_o, busy_o, done_o, err_o, |runs_o}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a;
    int en_base;
    int init_base;
    bit got;

    // Reset state
    tick(3);
    check_all_low("reset_outputs");
    reset_i = 1'b0;
    tick(1);
    check_all_low("idle_after_reset");

    // Target 5, with a start attempt mid-run that must be ignored
    en_base = en_seen; init_base = init_seen;
    start_run(4'd5, 0, 1'b1, a);
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    tick(3);
    target_i = 4'd1; start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(5);
    check("t5_latency", 32'(last_done - a), 32'd7);
    check("t5_count", 32'(m_count), 32'd5);
    check("t5_enables", 32'(en_seen - en_base), 32'd5);
    check("t5_inits", 32'(init_seen - init_base), 32'd1);
    check("t5_runs", 32'(runs_o), 32'd1);
    check("t5_idle", {31'd0, busy_o}, 32'd0);

    // Target 6 with a 3-cycle hold in the middle of counting
    en_base = en_seen;
    start_run(4'd6, 3, 1'b1, a);
    tick(3);
    hold_i = 1'b1;
    tick(2);
    check("hold_enable", {31'd0, enable_o}, 32'd0);
    check("hold_frozen", 32'(m_count), 32'd2);
    tick(1);
    hold_i = 1'b0;
    tick(7);
    check("t6_latency", 32'(last_done - a), 32'd11);
    check("t6_count", 32'(m_count), 32'd6);
    check("t6_enables", 32'(en_seen - en_base), 32'd6);
    check("t6_err", {31'd0, err_o}, 32'd0);
    check("t6_runs", 32'(runs_o), 32'd2);

    // Target 9, abort at count 4
    en_base = en_seen;
    start_run(4'd9, 0, 1'b0, a);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (count_i == 4'd4 && busy_o) begin got = 1'b1; break; end
      tick(1);
    end
    check("stop_reach4", {31'd0, got}, 32'd1);
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    check("stop_enable", {31'd0, enable_o}, 32'd0);
    check("stop_busy", {31'd0, busy_o}, 32'd0);
    tick(4);
    check("stop_count", 32'(m_count), 32'd5);
    check("stop_enables", 32'(en_seen - en_base), 32'd5);
    check("stop_runs", 32'(runs_o), 32'd2);

    // Stuck counter, target 3: watchdog trips, stop clears the error
    m_stuck = 1'b1;
    en_base = en_seen;
    start_run(4'd3, 0, 1'b0, a);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (err_o) begin got = 1'b1; break; end
      tick(1);
    end
    check("wd_err_seen", {31'd0, got}, 32'd1);
    check("wd_latency", 32'(cyc - a), 32'd17);
    check("wd_enables", 32'(en_seen - en_base), 32'd16);
    check("wd_enable_low", {31'd0, enable_o}, 32'd0);
    check("wd_busy", {31'd0, busy_o}, 32'd1);
    hold_i = 1'b1;
    tick(3);
    hold_i = 1'b0;
    check("wd_sticky", {31'd0, err_o}, 32'd1);
    check("wd_no_enable", 32'(en_seen - en_base), 32'd16);
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    check("wd_stop_err", {31'd0, err_o}, 32'd0);
    check("wd_stop_busy", {31'd0, busy_o}, 32'd0);

    // Trip again, then leave ERROR via start with a new target 2
    start_run(4'd3, 0, 1'b0, a);
    tick(18);
    check("wd2_err", {31'd0, err_o}, 32'd1);
    m_stuck = 1'b0;
    start_run(4'd2, 0, 1'b1, a);
    check("err_start_clear", {31'd0, err_o}, 32'd0);
    tick(5);
    check("t2_latency", 32'(last_done - a), 32'd4);
    check("t2_count", 32'(m_count), 32'd2);
    check("t2_runs", 32'(runs_o), 32'd3);

    // Target 0: no increments at all
    en_base = en_seen;
    start_run(4'd0, 0, 1'b1, a);
    tick(3);
    check("t0_latency", 32'(last_done - a), 32'd2);
    check("t0_enables", 32'(en_seen - en_base), 32'd0);
    check("t0_runs", 32'(runs_o), 32'd4);

    // Reset in the middle of a target-7 run
    start_run(4'd7, 0, 1'b1, a);
    tick(4);
    check("pre_reset_enable", {31'd0, enable_o}, 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check_all_low("async_reset");
    tick(2);
    reset_i = 1'b0;
    tick(1);
    check_all_low("after_reset");
    start_run(4'd3, 0, 1'b1, a);
    tick(6);
    check("post_reset_latency", 32'(last_done - a), 32'd5);
    check("post_reset_runs", 32'(runs_o), 32'd1);

    // Saturation of the run tally
    for (int i = 0; i < 256; i++) begin
      start_run(4'd0, 0, 1'b1, a);
      tick(3);
    end
    check("runs_saturated", 32'(runs_o), 32'd255);

    tick(3);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
